// File: rtl/gray_stream_convert.sv
// gray_stream_convert
//   Streaming RGB -> gray / black-and-white converter for the camera path.
//   Pulls FRAME_PIXELS pixels per frame from the upstream (SDRAM read) port.
//   For each pixel it emits a gray value and a thresholded BW bit downstream,
//   through a two-stage pipeline that honours downstream backpressure.
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_start              frame start pulse (only honoured while idle)
//   i_mode               0 luma, 1 (R+2G+B)>>2, 2 max(R,G,B), 3 green only
//   i_threshold          BW threshold (gray <= threshold is "dark")
//   i_invert             invert the BW bit
//   i_valid, o_ready     upstream pixel handshake (o_ready also drives the
//                        SDRAM read request)
//   i_red/green/blue     upstream pixel channels
//   o_valid, i_ready     downstream beat handshake
//   o_gray, o_bw         output gray value and BW bit
//   o_sof, o_eof         first / last pixel of the frame (qualified by o_valid)
//   o_busy               converter is inside a frame
//   o_frame_done         one-cycle pulse once the last beat has left
module gray_stream_convert #(
  parameter int PIX_W        = 10,
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = 20,
  parameter int FRAC         = 8,
  parameter int W_R          = 77,
  parameter int W_G          = 150,
  parameter int W_B          = 29
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [PIX_W-1:0] i_threshold,
  input  logic             i_invert,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_red,
  input  logic [PIX_W-1:0] i_green,
  input  logic [PIX_W-1:0] i_blue,
  output logic             o_ready,
  output logic [PIX_W-1:0] o_gray,
  output logic             o_bw,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int PROD_W = PIX_W + 8;
  localparam int SUM_W  = PIX_W + 10;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [SUM_W-1:0] GRAY_MAX = SUM_W'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [1:0]        mode;
  logic [PIX_W-1:0]  thr;
  logic              inv;

  logic              en;
  logic              accept;

  logic              s1_valid;
  logic              s1_sof;
  logic              s1_eof;
  logic [PROD_W-1:0] s1_a;
  logic [PROD_W-1:0] s1_b;
  logic [PROD_W-1:0] s1_c;

  logic [PROD_W-1:0] op_a;
  logic [PROD_W-1:0] op_b;
  logic [PROD_W-1:0] op_c;

  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  max_ab;
  logic [SUM_W-1:0]  max_abc;
  logic [SUM_W-1:0]  shifted;
  logic [PIX_W-1:0]  gray_next;
  logic              bw_next;

  // Whole pipeline advances together; it only freezes when a beat sits at
  // the output and downstream refuses it.
  assign en      = !o_valid || i_ready;
  assign o_ready = (state == RUN) && en;
  assign accept  = i_valid && o_ready;
  assign o_busy  = (state != IDLE);

  // Stage 1 operands. Mode 1 pre-doubles green so stage 2 is a plain sum.
  // Modes 2/3 carry raw channels; the selection happens in stage 2.
  always_comb begin
    op_a = '0;
    op_b = '0;
    op_c = '0;
    case (mode)
      2'd0: begin
        op_a = PROD_W'(i_red)   * PROD_W'(W_R);
        op_b = PROD_W'(i_green) * PROD_W'(W_G);
        op_c = PROD_W'(i_blue)  * PROD_W'(W_B);
      end
      2'd1: begin
        op_a = PROD_W'(i_red);
        op_b = PROD_W'({i_green, 1'b0});
        op_c = PROD_W'(i_blue);
      end
      2'd2: begin
        op_a = PROD_W'(i_red);
        op_b = PROD_W'(i_green);
        op_c = PROD_W'(i_blue);
      end
      default: begin
        op_b = PROD_W'(i_green);
      end
    endcase
  end

  // Stage 2: reduce, scale, saturate, threshold.
  always_comb begin
    sum     = SUM_W'(s1_a) + SUM_W'(s1_b) + SUM_W'(s1_c);
    max_ab  = (s1_a > s1_b) ? SUM_W'(s1_a) : SUM_W'(s1_b);
    max_abc = (max_ab > SUM_W'(s1_c)) ? max_ab : SUM_W'(s1_c);
    case (mode)
      2'd0:    shifted = sum >> FRAC;
      2'd1:    shifted = sum >> 2;
      2'd2:    shifted = max_abc;
      default: shifted = SUM_W'(s1_b);
    endcase
    gray_next = (shifted > GRAY_MAX) ? GRAY_MAX[PIX_W-1:0] : shifted[PIX_W-1:0];
    bw_next   = (gray_next <= thr) ^ inv;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      count        <= '0;
      mode         <= '0;
      thr          <= '0;
      inv          <= 1'b0;
      s1_valid     <= 1'b0;
      s1_sof       <= 1'b0;
      s1_eof       <= 1'b0;
      s1_a         <= '0;
      s1_b         <= '0;
      s1_c         <= '0;
      o_valid      <= 1'b0;
      o_gray       <= '0;
      o_bw         <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (i_start) begin
            state <= RUN;
            count <= '0;
            mode  <= i_mode;
            thr   <= i_threshold;
            inv   <= i_invert;
          end
        end
        RUN: begin
          if (accept) begin
            if (count == LAST_IDX) state <= DRAIN;
            else                   count <= count + 1'b1;
          end
        end
        DRAIN: begin
          // Fires on the edge where the final beat leaves the output stage
          // (or immediately if it has already gone).
          if (!s1_valid && en) begin
            state        <= IDLE;
            o_frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (en) begin
        s1_valid <= accept;
        if (accept) begin
          s1_a   <= op_a;
          s1_b   <= op_b;
          s1_c   <= op_c;
          s1_sof <= (count == '0);
          s1_eof <= (count == LAST_IDX);
        end
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_gray <= gray_next;
          o_bw   <= bw_next;
          o_sof  <= s1_sof;
          o_eof  <= s1_eof;
        end else begin
          o_sof  <= 1'b0;
          o_eof  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gray_stream_convert.sv
module tb_gray_stream_convert;

  localparam int PIX_W = 10;
  localparam int NPIX  = 16;
  localparam int CNT_W = 5;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [1:0]       i_mode = '0;
  logic [PIX_W-1:0] i_threshold = '0;
  logic             i_invert = 1'b0;
  logic             i_valid = 1'b0;
  logic [PIX_W-1:0] i_red = '0;
  logic [PIX_W-1:0] i_green = '0;
  logic [PIX_W-1:0] i_blue = '0;
  logic             o_ready;
  logic [PIX_W-1:0] o_gray;
  logic             o_bw;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic             o_sof;
  logic             o_eof;
  logic             o_busy;
  logic             o_frame_done;

  int checks = 0;
  int errors = 0;

  gray_stream_convert #(
    .PIX_W(PIX_W),
    .FRAME_PIXELS(NPIX),
    .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_start(i_start),
    .i_mode(i_mode),
    .i_threshold(i_threshold),
    .i_invert(i_invert),
    .i_valid(i_valid),
    .i_red(i_red),
    .i_green(i_green),
    .i_blue(i_blue),
    .o_ready(o_ready),
    .o_gray(o_gray),
    .o_bw(o_bw),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sof(o_sof),
    .o_eof(o_eof),
    .o_busy(o_busy),
    .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  // Reference gray value from the conversion rules in plain integer math.
  function automatic int ref_gray(input int mode, input int r, input int g, input int b);
    int v;
    case (mode)
      0: v = (r * 77 + g * 150 + b * 29) / 256;
      1: v = (r + 2 * g + b) / 4;
      2: begin
        v = r;
        if (g > v) v = g;
        if (b > v) v = b;
      end
      default: v = g;
    endcase
    if (v > 1023) v = 1023;
    return v;
  endfunction

  // Pulse start with the frame configuration, then scramble the config
  // inputs so any failure to latch shows up in the data.
  task automatic start_frame(input int mode, input int thr, input bit inv);
    @(negedge i_clk);
    i_start     = 1'b1;
    i_mode      = 2'(mode);
    i_threshold = PIX_W'(thr);
    i_invert    = inv;
    @(negedge i_clk);
    i_start     = 1'b0;
    i_mode      = 2'($urandom);
    i_threshold = PIX_W'($urandom);
    i_invert    = 1'($urandom);
  endtask

  // Runs one complete frame and checks every beat against the model.
  // fr/fg/fb < 0 means random channel; exp_gray >= 0 pins the required gray.
  // rdy_mode: 0 always ready, 1 toggle every cycle, 2 random.
  task automatic run_frame(input string name, input int mode, input int thr, input bit inv,
                           input int fr, input int fg, input int fb, input int exp_gray,
                           input int rdy_mode, input bit gaps, input bit start_noise);
    int r_a[NPIX];
    int g_a[NPIX];
    int b_a[NPIX];
    int sent, got, sofs, eofs, cyc, left_cyc, acc0, out0, req;
    bit pending, done_seen, prev_stall, drain_poked, ebw;
    logic [PIX_W-1:0] pg;
    logic pbw, psof, peof;
    for (int i = 0; i < NPIX; i++) begin
      r_a[i] = (fr >= 0) ? fr : int'($urandom_range(0, 1023));
      g_a[i] = (fg >= 0) ? fg : int'($urandom_range(0, 1023));
      b_a[i] = (fb >= 0) ? fb : int'($urandom_range(0, 1023));
    end
    start_frame(mode, thr, inv);
    sent = 0; got = 0; sofs = 0; eofs = 0; cyc = 0;
    left_cyc = -10; acc0 = -1; out0 = -1;
    pending = 0; done_seen = 0; prev_stall = 0; drain_poked = 0;
    pg = '0; pbw = 0; psof = 0; peof = 0;
    while (!done_seen && cyc < 3000) begin
      case (rdy_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = (cyc % 2 == 0);
        default: i_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (!pending && sent < NPIX) pending = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_valid = pending;
      if (pending) begin
        i_red   = PIX_W'(r_a[sent]);
        i_green = PIX_W'(g_a[sent]);
        i_blue  = PIX_W'(b_a[sent]);
      end
      i_start = 1'b0;
      if (start_noise && (cyc == 3 || (sent == NPIX && !drain_poked))) begin
        i_start     = 1'b1;
        i_mode      = 2'($urandom);
        i_threshold = PIX_W'($urandom);
        i_invert    = 1'($urandom);
        if (sent == NPIX) drain_poked = 1;
      end
      #1;
      if (sent == NPIX && !o_frame_done) begin
        checks++;
        if (o_ready !== 1'b0 || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL %s drain_state: ready=%0b busy=%0b, required ready=0 busy=1", name, o_ready, o_busy);
        end
      end
      if (o_frame_done === 1'b1) begin
        checks++;
        if (cyc != left_cyc + 1) begin
          errors++;
          $display("FAIL %s frame_done_timing: at cycle %0d, required cycle %0d", name, cyc, left_cyc + 1);
        end
        done_seen = 1;
      end
      if (prev_stall) begin
        checks++;
        if (o_valid !== 1'b1 || o_gray !== pg || o_bw !== pbw || o_sof !== psof || o_eof !== peof) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%0b gray=%0d bw=%0b sof=%0b eof=%0b, required valid=1 gray=%0d bw=%0b sof=%0b eof=%0b",
                   name, o_valid, o_gray, o_bw, o_sof, o_eof, pg, pbw, psof, peof);
        end
      end
      if (o_valid === 1'b1 && out0 < 0) out0 = cyc;
      if (o_valid === 1'b1 && i_ready) begin
        checks++;
        if (got >= NPIX) begin
          errors++;
          $display("FAIL %s extra_beat: beat %0d, required at most %0d beats", name, got, NPIX);
        end else begin
          req = (exp_gray >= 0) ? exp_gray : ref_gray(mode, r_a[got], g_a[got], b_a[got]);
          ebw = (req <= thr) ^ inv;
          if (o_gray !== PIX_W'(req) || o_bw !== ebw || o_sof !== (got == 0) || o_eof !== (got == NPIX - 1)) begin
            errors++;
            $display("FAIL %s beat %0d: gray=%0d bw=%0b sof=%0b eof=%0b, required gray=%0d bw=%0b sof=%0b eof=%0b",
                     name, got, o_gray, o_bw, o_sof, o_eof, req, ebw, got == 0, got == NPIX - 1);
          end
        end
        sofs += int'(o_sof);
        eofs += int'(o_eof);
        got++;
        if (got == NPIX) left_cyc = cyc;
      end
      prev_stall = (o_valid === 1'b1) && !i_ready;
      pg = o_gray; pbw = o_bw; psof = o_sof; peof = o_eof;
      if (i_valid && o_ready) begin
        if (acc0 < 0) acc0 = cyc;
        sent++;
        pending = 0;
      end
      @(negedge i_clk);
      cyc++;
    end
    i_valid = 1'b0;
    i_start = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s frame_done_timeout: not seen in %0d cycles, required a pulse", name, cyc);
    end
    checks++;
    if (got != NPIX || sofs != 1 || eofs != 1) begin
      errors++;
      $display("FAIL %s frame_totals: beats=%0d sof=%0d eof=%0d, required beats=%0d sof=1 eof=1", name, got, sofs, eofs, NPIX);
    end
    if (rdy_mode == 0 && !gaps) begin
      checks++;
      if (out0 - acc0 != 2) begin
        errors++;
        $display("FAIL %s latency: %0d cycles, required 2", name, out0 - acc0);
      end
    end
    $display("frame %s: mode=%0d thr=%0d inv=%0b beats=%0d sof=%0d eof=%0d cycles=%0d",
             name, mode, thr, inv, got, sofs, eofs, cyc);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (o_ready !== 1'b0 || o_gray !== '0 || o_bw !== 1'b0 || o_valid !== 1'b0 || o_sof !== 1'b0 ||
        o_eof !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s outputs: ready=%0b gray=%0d bw=%0b valid=%0b sof=%0b eof=%0b busy=%0b done=%0b, required all 0",
               name, o_ready, o_gray, o_bw, o_valid, o_sof, o_eof, o_busy, o_frame_done);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check_all_zero("reset_held");
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    check_all_zero("reset_released");
    $display("reset: checked outputs during and after reset");
  endtask

  task automatic test_saturate();
    run_frame("saturate", 0, 500, 0, 1023, 1023, 1023, 1023, 0, 0, 0);
  endtask

  task automatic test_luma_threshold();
    run_frame("luma_thr300", 0, 300, 0, 1023, 0, 0, 307, 0, 0, 0);
    run_frame("luma_thr307", 0, 307, 0, 1023, 0, 0, 307, 0, 0, 0);
    run_frame("luma_thr307_inv", 0, 307, 1, 1023, 0, 0, 307, 0, 0, 0);
  endtask

  task automatic test_modes();
    run_frame("mode1", 1, 150, 0, 100, 200, 40, 135, 0, 0, 0);
    run_frame("mode2", 2, 150, 0, 100, 200, 40, 200, 0, 0, 0);
    run_frame("mode3", 3, 250, 1, 100, 200, 40, 200, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    run_frame("toggle_ready", 0, 400, 0, -1, -1, -1, -1, 1, 0, 0);
    run_frame("random_ready", 1, 600, 1, -1, -1, -1, -1, 2, 1, 0);
  endtask

  task automatic test_start_ignored();
    run_frame("start_noise", 2, 700, 0, -1, -1, -1, -1, 0, 0, 1);
    run_frame("after_noise", 0, 300, 0, -1, -1, -1, -1, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      run_frame("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)), 1'($urandom),
                -1, -1, -1, -1, 2, 1, 0);
    end
  endtask

  task automatic test_reset_midframe();
    int sent;
    int cyc;
    start_frame(0, 512, 0);
    sent = 0;
    cyc = 0;
    i_ready = 1'b1;
    while (sent < 5 && cyc < 200) begin
      i_valid = 1'b1;
      i_red   = PIX_W'($urandom);
      i_green = PIX_W'($urandom);
      i_blue  = PIX_W'($urandom);
      #1;
      if (o_ready) sent++;
      @(negedge i_clk);
      cyc++;
    end
    checks++;
    if (sent != 5) begin
      errors++;
      $display("FAIL reset_mid accept: %0d pixels accepted, required 5", sent);
    end
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    check_all_zero("reset_mid_edge");
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check_all_zero("reset_mid_hold");
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_all_zero("reset_mid_release");
    $display("reset_midframe: reset after %0d pixels, outputs cleared", sent);
    run_frame("after_reset", 0, 512, 0, -1, -1, -1, -1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_luma_threshold();
    test_modes();
    test_backpressure();
    test_start_ignored();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
